// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial line, validates the start bit at mid-bit,
// shifts in 8 data bits LSB first, checks the stop bit and strobes o_done or o_frame_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  output logic [7:0] o_data,
  output logic       o_done,
  output logic       o_active,
  output logic       o_frame_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  state_e                 state_q;
  logic [CW-1:0]          clk_cnt_q;
  logic [2:0]             bit_idx_q;
  logic [7:0]             shift_q;
  logic [7:0]             data_q;
  logic                   done_q;
  logic                   active_q;
  logic                   frame_err_q;

  // Preset to 1 so a reset never looks like the leading edge of a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      active_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          clk_cnt_q <= '0;
          if (!rx_s) begin
            state_q  <= S_START;
            active_q <= 1'b1;
          end
        end
        S_START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            if (!rx_s) begin
              state_q <= S_DATA;
            end else begin
              state_q  <= S_IDLE;
              active_q <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (clk_cnt_q == FULL_LAST) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (clk_cnt_q == FULL_LAST) begin
            clk_cnt_q <= '0;
            if (rx_s) begin
              data_q   <= shift_q;
              done_q   <= 1'b1;
              state_q  <= S_IDLE;
              active_q <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        S_BREAK: begin
          // A held-low line must return high before another start bit is accepted.
          clk_cnt_q <= '0;
          if (rx_s) begin
            state_q  <= S_IDLE;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_done      = done_q;
  assign o_active    = active_q;
  assign o_frame_err = frame_err_q;

endmodule
